// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide path: op encodings, FSM states, default latencies.
// Pure definitions, no logic and no latency.
// No flow control; Id decode, Ex and the stall selector all import these values.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the four ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_md_arith.sv
// Combinational signed/unsigned multiply and divide producing a 64-bit {hi,lo} and a divide-by-zero flag.
// Zero latency; purely combinational.
// No flow control; the caller decides when to capture the result.
module md_arith
    import mul_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] b_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        b_safe = (b == 32'd0) ? 32'd1 : b;
        if (op == MD_DIV) begin
            mag_a = a[31] ? (32'd0 - a) : a;
            mag_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        end else begin
            mag_a = a;
            mag_b = b_safe;
        end
        uq = mag_a / mag_b;
        ur = mag_a % mag_b;
        sq = (a[31] ^ b_safe[31]) ? (32'd0 - uq) : uq;
        sr = a[31] ? (32'd0 - ur) : ur;
    end

    // Select the result for the requested op; non-arithmetic ops yield zero.
    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (md_op_t'(op))
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_hi   = sr;
                res_lo   = sq;
                div_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                res_hi   = ur;
                res_lo   = uq;
                div_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: computes at request, then holds ifBusy for MULT_CYCLES or DIV_CYCLES.
// Result commits to hi/lo on the cycle ifBusy drops; mthi/mtlo land one edge after being presented.
// Requests, mthi and mtlo arriving while busy are dropped; the stall selector keys off ifBusy.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifStart,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        ifBusy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = 16;

    md_state_t   state;
    md_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;
    logic        load;
    logic        commit;
    logic        wr_hi;
    logic        wr_lo;
    logic        is_div;

    md_arith u_arith (
        .op       (mdOp),
        .a        (srcA),
        .b        (srcB),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign is_div = (mdOp == MD_DIV) || (mdOp == MD_DIVU);
    assign ifBusy = (state == ST_BUSY);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and control strobes; mthi/mtlo only act in IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ifStart && is_start_op(mdOp)) begin
                    load      = 1'b1;
                    state_nxt = ST_BUSY;
                end else begin
                    wr_hi = (mdOp == MD_MTHI);
                    wr_lo = (mdOp == MD_MTLO);
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counter, pending result and architectural HI/LO. A divide by zero parks the current
    // hi/lo as the pending value so the commit leaves them unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (load) begin
                cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi <= div_zero ? hi : res_hi;
                pend_lo <= div_zero ? lo : res_lo;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (wr_hi) hi <= srcA;
            if (wr_lo) lo <= srcA;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random ops against a 64-bit model.
// Expected results and busy lengths are queued at request time and checked when ifBusy falls.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifStart;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        ifBusy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_busy = 1'b0;
    int   busy_len  = 0;
    logic abort_pending = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .ifStart (ifStart),
        .mdOp    (mdOp),
        .srcA    (srcA),
        .srcB    (srcB),
        .ifBusy  (ifBusy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit arithmetic, independent of the unit's magnitude-based divider.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return cur;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    // Scoreboard: on each busy->idle transition, pop and compare result and busy length.
    always @(negedge clk) begin
        exp_t e;
        if (ifBusy) begin
            busy_len++;
        end else if (prev_busy) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
            end else if (exp_q.size() == 0) begin
                chk("unexpected_commit", 64'(busy_len), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_hilo", {hi, lo}, {e.hi, e.lo});
                chk("busy_len", 64'(busy_len), 64'(e.len));
            end
            busy_len = 0;
        end
        prev_busy = ifBusy;
    end

    task automatic wait_idle;
        int i;
        for (i = 0; i < 40; i++) begin
            if (!ifBusy) break;
            tick();
        end
        if (ifBusy) chk("idle_timeout", 64'(ifBusy), 64'd0);
        tick();
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] len);
        logic [63:0] r;
        r = model(op, a, b, {m_hi, m_lo});
        exp_q.push_back('{hi: r[63:32], lo: r[31:0], len: len});
        m_hi = r[63:32];
        m_lo = r[31:0];
        ifStart = 1'b1; mdOp = op; srcA = a; srcB = b;
        tick();
        ifStart = 1'b0; mdOp = 3'd0;
        wait_idle();
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        mdOp = op; srcA = v;
        tick();
        mdOp = 3'd0;
        if (op == 3'd5) m_hi = v; else m_lo = v;
    endtask

    initial begin
        reset = 1'b1; ifStart = 1'b0; mdOp = 3'd0; srcA = '0; srcB = '0;
        tick(); tick();
        chk("reset_busy", 64'(ifBusy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        tick();

        // mult -2 * 3
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 5);
        chk("mult_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
        // divu 7/2, div -7/2
        do_op(3'd4, 32'd7, 32'd2, 10);
        chk("divu_hilo", {hi, lo}, {32'd1, 32'd3});
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 10);
        chk("div_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        // divide by zero leaves hi/lo untouched
        mt(3'd5, 32'h1234);
        mt(3'd6, 32'h5678);
        do_op(3'd3, 32'd99, 32'd0, 10);
        chk("divzero_hilo", {hi, lo}, {32'h1234, 32'h5678});

        // INT_MIN / -1 wraps
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        chk("div_wrap", {hi, lo}, {32'd0, 32'h80000000});

        // mthi then mtlo back to back
        mdOp = 3'd5; srcA = 32'hAAAA0000;
        #1;
        chk("mthi_not_comb", 64'(hi), 64'd0);
        tick();
        chk("mthi_hi", 64'(hi), 64'hAAAA0000);
        chk("mthi_busy", 64'(ifBusy), 64'd0);
        mdOp = 3'd6; srcA = 32'h0000BBBB;
        tick();
        mdOp = 3'd0;
        chk("mtlo_hilo", {hi, lo}, {32'hAAAA0000, 32'h0000BBBB});
        chk("mtlo_busy", 64'(ifBusy), 64'd0);
        m_hi = 32'hAAAA0000; m_lo = 32'h0000BBBB;

        // requests while busy are ignored
        exp_q.push_back('{hi: 32'h1, lo: 32'hFFFFFFFE, len: 5});
        m_hi = 32'h1; m_lo = 32'hFFFFFFFE;
        ifStart = 1'b1; mdOp = 3'd2; srcA = 32'hFFFFFFFF; srcB = 32'd2;
        tick();
        ifStart = 1'b0; mdOp = 3'd6; srcA = 32'h1;
        tick();
        ifStart = 1'b1; mdOp = 3'd1; srcA = 32'd7; srcB = 32'd9;
        tick();
        ifStart = 1'b0; mdOp = 3'd0;
        wait_idle();
        chk("ignored_hilo", {hi, lo}, {32'h1, 32'hFFFFFFFE});

        // random ops against the model
        for (int k = 0; k < 8; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(1, 4));
            a  = $urandom();
            b  = (k == 3) ? 32'd0 : ((k[0]) ? 32'($urandom_range(1, 300)) : $urandom());
            do_op(op, a, b, (op >= 3'd3) ? 32'd10 : 32'd5);
        end

        // reset in busy cycle 4 aborts with no later commit
        abort_pending = 1'b1;
        ifStart = 1'b1; mdOp = 3'd3; srcA = 32'd100; srcB = 32'd7;
        tick();
        ifStart = 1'b0; mdOp = 3'd0;
        tick(); tick(); tick();
        chk("pre_reset_busy", 64'(ifBusy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(ifBusy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        for (int k = 0; k < 15; k++) tick();
        chk("abort_no_commit", {hi, lo}, 64'd0);
        chk("abort_idle", 64'(ifBusy), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
